axi_rd_burst_scheduler: RTL and testbench

AXI_RD_BURST_SCHEDULER -- requirements
Module: axi_rd_burst_scheduler

---
 rtl/axi_rd_burst_scheduler_pkg.sv | 28 ++
 rtl/axi_rd_burst_scheduler_rr_arbiter2.sv | 40 ++++
 rtl/axi_rd_burst_scheduler.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_burst_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_burst_scheduler_pkg.sv
// Shared definitions for the AXI read burst scheduler.
//   state_e        : scheduler FSM encoding
//   AXI_BURST_INCR : AXI4 INCR burst type
//   AXI_RESP_OKAY  : AXI4 OKAY response
//   bytes_per_beat : bytes carried by one data beat of a given bus width
//   axi_size       : AxSIZE encoding for a given bus width
package axi_rd_burst_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        NEXT = 3'd4
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_rd_burst_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   M_AXI_ACLK    : clock
//   M_AXI_ARESETN : asynchronous active-low reset
//   req_i[1:0]    : request vector
//   accept_i      : grant is consumed this cycle; updates the last-grant record
//   gnt_o[1:0]    : one-hot grant (zero when nothing requests)
// On a tie the requester that was not granted last wins. Last-grant resets
// to 1 so requester 0 wins the first tie.
module rr_arbiter2
    import axi_rd_burst_scheduler_pkg::*;
(
    input  logic       M_AXI_ACLK,
    input  logic       M_AXI_ARESETN,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_rd_burst_scheduler.sv
// Video line-fetch scheduler: arbitrates two line requesters and reads each
// granted line from its frame buffer as a sequence of AXI4 INCR bursts, one
// burst in flight at a time, streaming R beats straight into the requester's
// line FIFO.
//   M_AXI_ACLK / M_AXI_ARESETN : clock, asynchronous active-low reset
//   req_valid/req_sof/req_ready: per-requester line request handshake
//   fifo_full/fifo_wr_en/fifo_wr_data : per-requester FIFO write side
//   m_axi_ar* / m_axi_r*       : AXI4 read address and read data channels
//   rd_err                     : sticky, set by any non-OKAY rresp
module axi_rd_burst_scheduler
    import axi_rd_burst_scheduler_pkg::*;
#(
    parameter int                         AXI4_DATA_WIDTH = 128,
    parameter int                         AXI4_ADDR_WIDTH = 32,
    parameter int                         LINE_BEATS      = 480,
    parameter int                         BURST_LEN       = 32,
    parameter int                         V_DISP          = 1080,
    parameter logic [AXI4_ADDR_WIDTH-1:0] BASE_ADDR_0     = 32'h0000_0000,
    parameter logic [AXI4_ADDR_WIDTH-1:0] BASE_ADDR_1     = 32'h0100_0000
) (
    input  logic                       M_AXI_ACLK,
    input  logic                       M_AXI_ARESETN,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_sof,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 fifo_full,
    output logic [1:0]                 fifo_wr_en,
    output logic [AXI4_DATA_WIDTH-1:0] fifo_wr_data,
    output logic [AXI4_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [AXI4_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic                       rd_err
);

    localparam int BPB    = bytes_per_beat(AXI4_DATA_WIDTH);
    localparam int NBURST = LINE_BEATS / BURST_LEN;
    localparam int LINE_W = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int CNT_W  = $clog2(NBURST + 1);
    localparam logic [AXI4_ADDR_WIDTH-1:0] LINE_BYTES  = AXI4_ADDR_WIDTH'(LINE_BEATS * BPB);
    localparam logic [AXI4_ADDR_WIDTH-1:0] BURST_BYTES = AXI4_ADDR_WIDTH'(BURST_LEN * BPB);

    state_e                          state_q, state_d;
    logic                            gnt_q, gnt_d;       // index of requester being served
    logic [1:0][LINE_W-1:0]          line_q, line_d;     // last line fetched per requester
    logic [AXI4_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]                bcnt_q, bcnt_d;     // bursts issued for current line
    logic                            rd_err_q, rd_err_d;

    logic [1:0]                 arb_gnt;
    logic                       arb_sel;
    logic [LINE_W-1:0]          next_line;
    logic [AXI4_ADDR_WIDTH-1:0] start_addr;
    logic                       r_hs;

    rr_arbiter2 u_arb (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .req_i         (req_valid),
        .accept_i      (state_q == ARB),
        .gnt_o         (arb_gnt)
    );

    assign arb_sel    = arb_gnt[1];
    assign next_line  = req_sof[arb_sel] ? '0 :
                        (line_q[arb_sel] == LINE_W'(V_DISP - 1)) ? '0 :
                        line_q[arb_sel] + 1'b1;
    assign start_addr = (arb_sel ? BASE_ADDR_1 : BASE_ADDR_0)
                      + AXI4_ADDR_WIDTH'(next_line) * LINE_BYTES;

    // Beat accepted: only in DATA and only while the served FIFO has room.
    assign r_hs = (state_q == DATA) && m_axi_rvalid && !fifo_full[gnt_q];

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = axi_size(AXI4_DATA_WIDTH);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign fifo_wr_data  = m_axi_rdata;
    assign rd_err        = rd_err_q;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        line_d        = line_q;
        addr_d        = addr_q;
        bcnt_d        = bcnt_q;
        rd_err_d      = rd_err_q | (r_hs && (m_axi_rresp != AXI_RESP_OKAY));
        req_ready     = 2'b00;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        fifo_wr_en    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) state_d = ARB;
            end
            ARB: begin
                if (|arb_gnt) begin
                    req_ready        = arb_gnt;
                    gnt_d            = arb_sel;
                    line_d[arb_sel]  = next_line;
                    addr_d           = start_addr;
                    bcnt_d           = '0;
                    state_d          = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    bcnt_d  = bcnt_q + 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                m_axi_rready = !fifo_full[gnt_q];
                if (r_hs) begin
                    fifo_wr_en[gnt_q] = 1'b1;
                    // Early rlast simply ends the burst; beats are not counted.
                    if (m_axi_rlast) state_d = NEXT;
                end
            end
            NEXT: begin
                if (bcnt_q < CNT_W'(NBURST)) begin
                    addr_d  = addr_q + BURST_BYTES;
                    state_d = ADDR;
                end else begin
                    state_d = (|req_valid) ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            line_q   <= '0;
            addr_q   <= '0;
            bcnt_q   <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            rd_err_q <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_scheduler.sv
module tb_axi_rd_burst_scheduler;

    localparam int DW = 128, AW = 32, LB = 480, BL = 32, VD = 1080;
    localparam int NB = LB / BL, BPB = DW / 8;

    logic          clk, rst_n;
    logic [1:0]    req_valid, req_sof, req_ready, fifo_full, fifo_wr_en;
    logic [DW-1:0] fifo_wr_data, m_axi_rdata;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst, m_axi_rresp;
    logic          m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready, rd_err;

    axi_rd_burst_scheduler dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_sof(req_sof), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a, input int beat);
        return {a, 32'(beat), ~a, a ^ 32'h5A5A_0000 ^ 32'(beat)};
    endfunction

    // Scoreboard
    typedef struct packed { logic g; logic [DW-1:0] d; } wr_t;
    logic [AW-1:0] exp_ar[$];
    wr_t           exp_wr[$];
    logic [1:0]    exp_gnt[$];
    logic          rq0[$], rq1[$];
    int            mline[2];
    logic          exp_err;

    // Reference model of line sequencing / addressing; queues the request too.
    task automatic push_line(input int g, input bit sof, input int early_n);
        int line, nbeats;
        logic [AW-1:0] a, ba;
        line = sof ? 0 : ((mline[g] == VD - 1) ? 0 : mline[g] + 1);
        mline[g] = line;
        a = (g != 0 ? 32'h0100_0000 : 32'h0) + AW'(line * LB * BPB);
        exp_gnt.push_back(g != 0 ? 2'b10 : 2'b01);
        for (int b = 0; b < NB; b++) begin
            ba = a + AW'(b * BL * BPB);
            exp_ar.push_back(ba);
            nbeats = (b == 0 && early_n >= 0) ? early_n + 1 : BL;
            for (int k = 0; k < nbeats; k++) exp_wr.push_back('{g[0], mkdata(ba, k)});
        end
        if (g == 0) rq0.push_back(sof); else rq1.push_back(sof);
    endtask

    // Slave / requester agent state
    bit            sbusy, err_arm, early_arm, ar_rand, full_chk, want_first, prev_ar_wait;
    int            sbeat, early_n;
    logic [AW-1:0] saddr, ar_s, prev_addr, last_first_ar;
    logic          ar_hs, r_hs, rlast_s;
    logic [1:0]    rdy_s;
    logic [1:0]    eg;
    wr_t           ew;

    always begin
        @(negedge clk);
        if (rst_n) begin
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            rlast_s = m_axi_rlast;
            ar_s  = m_axi_araddr;
            rdy_s = req_ready;
            if (prev_ar_wait) check("araddr_stable", m_axi_araddr, prev_addr);
            prev_ar_wait = m_axi_arvalid && !m_axi_arready;
            prev_addr = m_axi_araddr;
            if (ar_hs) begin
                check("ar_expected", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) check("araddr", m_axi_araddr, exp_ar.pop_front());
                check("arlen", m_axi_arlen, 8'd31);
                check("arsize", m_axi_arsize, 3'd4);
                check("arburst", m_axi_arburst, 2'b01);
                if (want_first) begin last_first_ar = ar_s; want_first = 0; end
            end
            if (r_hs) begin
                check("wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    ew = exp_wr.pop_front();
                    check("fifo_wr_en", fifo_wr_en, ew.g ? 2'b10 : 2'b01);
                    check("fifo_wr_data", fifo_wr_data, ew.d);
                end
            end else begin
                check("fifo_wr_idle", fifo_wr_en, 2'b00);
            end
            if (req_ready != 2'b00) begin
                check("gnt_expected", exp_gnt.size() > 0, 1);
                if (exp_gnt.size() > 0) begin
                    eg = exp_gnt.pop_front();
                    check("req_ready", req_ready, eg);
                end
                want_first = 1;
            end
            if (full_chk && fifo_full[0]) check("rready_full", m_axi_rready, 0);
            check("rd_err", rd_err, exp_err);
            if (r_hs && m_axi_rresp != 2'b00) exp_err = 1'b1;
        end else begin
            ar_hs = 0; r_hs = 0; rdy_s = 0; prev_ar_wait = 0; want_first = 0;
        end
        @(posedge clk); #1;
        if (!rst_n) begin
            sbusy = 0; sbeat = 0;
            m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_arready = 1;
            req_valid = 0; req_sof = 0;
        end else begin
            if (ar_hs) begin
                sbusy = 1; saddr = ar_s; sbeat = 0;
            end else if (r_hs) begin
                if (err_arm && sbeat == 7) err_arm = 0;
                if (rlast_s) begin
                    sbusy = 0;
                    if (early_arm && sbeat == early_n) early_arm = 0;
                end else sbeat++;
            end
            m_axi_rvalid  = sbusy;
            m_axi_rdata   = mkdata(saddr, sbeat);
            m_axi_rlast   = sbusy && (sbeat == BL - 1 || (early_arm && sbeat == early_n));
            m_axi_rresp   = (sbusy && err_arm && sbeat == 7) ? 2'b10 : 2'b00;
            m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy_s[0]) req_valid[0] = 0;
            if (rdy_s[1]) req_valid[1] = 0;
            if (!req_valid[0] && rq0.size() > 0) begin req_valid[0] = 1; req_sof[0] = rq0.pop_front(); end
            if (!req_valid[1] && rq1.size() > 0) begin req_valid[1] = 1; req_sof[1] = rq1.pop_front(); end
        end
    end

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_ar.size() != 0 || exp_gnt.size() != 0 ||
                rq0.size() != 0 || rq1.size() != 0 || req_valid != 2'b00) && n < budget) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #2;
        check(tag, n < budget, 1);
    endtask

    task automatic wait_wr(input string tag, input int k, input int budget);
        int n = 0;
        while (exp_wr.size() > k && n < budget) begin @(posedge clk); n++; end
        #2;
        check(tag, n < budget, 1);
    endtask

    task automatic reset_model();
        exp_ar.delete(); exp_wr.delete(); exp_gnt.delete(); rq0.delete(); rq1.delete();
        mline[0] = 0; mline[1] = 0; exp_err = 0; err_arm = 0; early_arm = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, m_axi_arvalid, 0);
        check({tag, "_rready"}, m_axi_rready, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_fifo_wr_en"}, fifo_wr_en, 0);
        check({tag, "_rd_err"}, rd_err, 0);
        check({tag, "_araddr"}, m_axi_araddr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; req_valid = 0; req_sof = 0; fifo_full = 0;
        m_axi_arready = 1; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rdata = '0;
        ar_rand = 0; full_chk = 0; early_n = -1; last_first_ar = '1;
        reset_model();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1;

        // Both requesters in the same cycle straight after reset: 0,1,0,1
        push_line(0, 1, -1); push_line(1, 1, -1); push_line(0, 0, -1); push_line(1, 0, -1);
        wait_done("t_rr_done", 3000);

        // Single requester 0, start of frame
        push_line(0, 1, -1);
        wait_done("t_single_done", 800);
        check("t_single_first_ar", last_first_ar, 32'h0000_0000);

        // Requester 1 lines 2..5 with a stalling AR channel; last is line 5
        ar_rand = 1;
        for (int i = 0; i < 4; i++) push_line(1, 0, -1);
        wait_done("t_line5_done", 4000);
        check("t_line5_first_ar", last_first_ar, 32'h0100_9600);
        ar_rand = 0;

        // FIFO back-pressure mid-burst
        push_line(0, 0, -1);
        wait_wr("t_full_start", LB - 40, 200);
        fifo_full[0] = 1; full_chk = 1;
        repeat (10) @(posedge clk);
        #2;
        fifo_full[0] = 0; full_chk = 0;
        wait_done("t_full_done", 800);

        // Error response on beat 7
        err_arm = 1;
        push_line(0, 0, -1);
        wait_done("t_err_done", 800);
        check("t_err_sticky", rd_err, 1);

        // Early rlast on first burst
        early_n = 9; early_arm = 1;
        push_line(0, 0, 9);
        wait_done("t_early_done", 800);

        // Reset in the middle of a burst
        push_line(0, 1, -1);
        wait_wr("t_rst_start", LB - 10, 200);
        rst_n = 0;
        #1;
        check_reset_outputs("t_rst");
        reset_model();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
        push_line(0, 1, -1);
        wait_done("t_rst_done", 800);
        check("t_rst_first_ar", last_first_ar, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
